// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: requester handshakes, read-return paths and memory-side signals of imem_arbiter.
interface imem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic              d_prio;
    modport master (
        output f_req, f_addr, d_req, d_addr, mem_dout,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_addr, d_prio
    );
    modport slave (
        input  f_req, f_addr, d_req, d_addr, mem_dout,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_addr, d_prio
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-ported instruction memory between fetch (F) and debug (D) readers,
// fetch-first with an anti-starvation escape for D and a fixed-latency tag pipeline for returns.
module imem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input logic         clk,
    input logic         reset,
    imem_arbiter_if.slave bus
);
    typedef enum logic {FPRI, DPRI} state_e;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RD_LATENCY-1:0] vld_q, prt_q;
    logic f_gnt, d_gnt, starve, at_limit;
    always_comb begin
        f_gnt    = ~reset & bus.f_req & (state_q == FPRI | ~bus.d_req);
        d_gnt    = ~reset & bus.d_req & ~f_gnt;
        starve   = state_q == FPRI & bus.d_req & ~d_gnt;
        at_limit = cnt_q == CNT_W'(STARVE_LIMIT - 1);
        state_d  = starve & at_limit ? DPRI : FPRI;
        cnt_d    = starve & ~at_limit ? cnt_q + 1'b1 : '0;
    end
    // Tag pipeline: bit 0 is the newest issue, bit RD_LATENCY-1 is the word returning now.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FPRI;
            cnt_q   <= '0;
            vld_q   <= '0;
            prt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= RD_LATENCY'({vld_q, f_gnt | d_gnt});
            prt_q   <= RD_LATENCY'({prt_q, d_gnt});
        end
    end
    assign bus.f_gnt    = f_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.mem_en   = f_gnt | d_gnt;
    assign bus.mem_addr = f_gnt ? bus.f_addr : d_gnt ? bus.d_addr : '0;
    assign bus.f_rvalid = ~reset & vld_q[RD_LATENCY-1] & ~prt_q[RD_LATENCY-1];
    assign bus.d_rvalid = ~reset & vld_q[RD_LATENCY-1] & prt_q[RD_LATENCY-1];
    assign bus.f_rdata  = bus.mem_dout;
    assign bus.d_rdata  = bus.mem_dout;
    assign bus.d_prio   = ~reset & state_q == DPRI;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scenarios plus a randomized run against a run-length/scoreboard model.
module tb_imem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SL = 4;
    logic clk = 0;
    logic reset = 1;
    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    always #5 clk = ~clk;
    imem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    imem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();
    imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .STARVE_LIMIT(SL)) u_dut (
        .clk(clk), .reset(reset), .bus(bus));
    imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3), .STARVE_LIMIT(SL)) u_dut3 (
        .clk(clk), .reset(reset), .bus(bus3));
    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return DW'(32'(a) * 32'h9E37_79B1 ^ 32'h00C0_FFEE);
    endfunction
    // Memories: content is a hash of the address, returned 1 and 3 cycles after the address.
    logic [AW-1:0] ma1;
    logic [AW-1:0] ma3 [3];
    always @(posedge clk) begin
        ma1    <= bus.mem_addr;
        ma3[0] <= bus3.mem_addr;
        ma3[1] <= ma3[0];
        ma3[2] <= ma3[1];
    end
    assign bus.mem_dout  = word(ma1);
    assign bus3.mem_dout = word(ma3[2]);
    // Model: D gets priority after SL consecutive denied cycles; grants queued for return next cycle.
    typedef struct {int due; bit port; logic [AW-1:0] addr;} rsp_t;
    rsp_t q[$];
    int m_run = 0;
    logic e_dprio, e_fg, e_dg, e_fr, e_dr;
    logic [AW-1:0] e_addr;
    always_comb begin
        e_dprio = !reset && m_run >= SL;
        e_fg    = !reset && bus.f_req && !(e_dprio && bus.d_req);
        e_dg    = !reset && bus.d_req && !e_fg;
        e_addr  = e_fg ? bus.f_addr : e_dg ? bus.d_addr : '0;
        e_fr    = !reset && q.size() > 0 && q[0].due == cyc && !q[0].port;
        e_dr    = !reset && q.size() > 0 && q[0].due == cyc && q[0].port;
    end
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_run <= 0;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
            if (e_fg || e_dg) q.push_back('{cyc + 1, e_dg, e_addr});
            m_run <= (bus.d_req && !e_dg) ? m_run + 1 : 0;
        end
        cyc <= cyc + 1;
    end
    task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic dr, input logic [AW-1:0] da);
        bus.f_req  = fr;
        bus.f_addr = fa;
        bus.d_req  = dr;
        bus.d_addr = da;
    endtask
    task automatic next();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        reset = 1;
        drive(1, 7, 1, 9);
        next();
        @(negedge clk);
        nchk++;
        if ({bus.f_gnt, bus.d_gnt, bus.mem_en} !== 3'b000) begin
            nerr++; $display("FAIL reset_gnt: got f/d/en=%b%b%b want 000", bus.f_gnt, bus.d_gnt, bus.mem_en);
        end
        nchk++;
        if (bus.mem_addr !== '0) begin
            nerr++; $display("FAIL reset_addr: got %0d want 0", bus.mem_addr);
        end
        nchk++;
        if ({bus.f_rvalid, bus.d_rvalid, bus.d_prio} !== 3'b000) begin
            nerr++; $display("FAIL reset_status: got rv f/d prio=%b%b%b want 000", bus.f_rvalid, bus.d_rvalid, bus.d_prio);
        end
        next();
        reset = 0;
        drive(0, 0, 0, 0);
        @(negedge clk);
        nchk++;
        if ({bus.mem_en, bus.mem_addr} !== {1'b0, AW'(0)}) begin
            nerr++; $display("FAIL idle_addr: got en=%b addr=%0d want 0/0", bus.mem_en, bus.mem_addr);
        end
        next();
    endtask
    task automatic test_fetch();
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, AW'(i), 0, 0);
            @(negedge clk);
            if (i < 3) begin
                nchk++;
                if ({bus.f_gnt, bus.d_gnt, bus.mem_addr} !== {2'b10, AW'(i)}) begin
                    nerr++; $display("FAIL fetch_gnt%0d: got f/d=%b%b addr=%0d want 10/%0d", i, bus.f_gnt, bus.d_gnt, bus.mem_addr, i);
                end
            end
            nchk++;
            if ({bus.f_rvalid, bus.d_rvalid} !== {i > 0, 1'b0}) begin
                nerr++; $display("FAIL fetch_rv%0d: got f/d=%b%b want %b0", i, bus.f_rvalid, bus.d_rvalid, i > 0);
            end
            if (i > 0) begin
                nchk++;
                if (bus.f_rdata !== word(AW'(i - 1))) begin
                    nerr++; $display("FAIL fetch_data%0d: got %h want %h", i, bus.f_rdata, word(AW'(i - 1)));
                end
            end
            next();
        end
    endtask
    task automatic test_starve();
        for (int c = 0; c < 6; c++) begin
            drive(1, AW'(c < 4 ? 20 + c : 24), c < 5, 512);
            @(negedge clk);
            nchk++;
            if ({bus.f_gnt, bus.d_gnt, bus.d_prio} !== (c == 4 ? 3'b011 : 3'b100)) begin
                nerr++; $display("FAIL starve_c%0d: got f/d/prio=%b%b%b want %b", c, bus.f_gnt, bus.d_gnt, bus.d_prio, c == 4 ? 3'b011 : 3'b100);
            end
            if (c == 4) begin
                nchk++;
                if (bus.mem_addr !== AW'(512)) begin
                    nerr++; $display("FAIL starve_addr: got %0d want 512", bus.mem_addr);
                end
            end
            if (c == 5) begin
                nchk++;
                if ({bus.d_rvalid, bus.f_rvalid, bus.d_rdata} !== {2'b10, word(512)}) begin
                    nerr++; $display("FAIL starve_ret: got d/f rv=%b%b data=%h want 10/%h", bus.d_rvalid, bus.f_rvalid, bus.d_rdata, word(512));
                end
            end
            next();
        end
        drive(0, 0, 0, 0);
        next();
    endtask
    task automatic test_debug();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, c < 2, AW'(513 + c));
            @(negedge clk);
            if (c < 2) begin
                nchk++;
                if ({bus.d_gnt, bus.f_gnt, bus.d_prio, bus.mem_addr} !== {3'b100, AW'(513 + c)}) begin
                    nerr++; $display("FAIL debug_gnt%0d: got d/f/prio=%b%b%b addr=%0d want 100/%0d", c, bus.d_gnt, bus.f_gnt, bus.d_prio, bus.mem_addr, 513 + c);
                end
            end
            if (c > 0) begin
                nchk++;
                if ({bus.d_rvalid, bus.f_rvalid, bus.d_rdata} !== {2'b10, word(AW'(512 + c))}) begin
                    nerr++; $display("FAIL debug_ret%0d: got d/f rv=%b%b data=%h want 10/%h", c, bus.d_rvalid, bus.f_rvalid, bus.d_rdata, word(AW'(512 + c)));
                end
            end
            next();
        end
    endtask
    task automatic test_withdraw();
        for (int c = 0; c < 8; c++) begin
            drive(1, 30, c != 2, 700);
            @(negedge clk);
            nchk++;
            if ({bus.f_gnt, bus.d_gnt, bus.d_prio} !== (c == 7 ? 3'b011 : 3'b100)) begin
                nerr++; $display("FAIL withdraw_c%0d: got f/d/prio=%b%b%b want %b", c, bus.f_gnt, bus.d_gnt, bus.d_prio, c == 7 ? 3'b011 : 3'b100);
            end
            next();
        end
        drive(0, 0, 0, 0);
        next();
    endtask
    task automatic test_reset_mid();
        drive(1, 5, 0, 0);
        @(negedge clk);
        nchk++;
        if ({bus.f_gnt, bus.mem_addr} !== {1'b1, AW'(5)}) begin
            nerr++; $display("FAIL rmid_gnt: got f=%b addr=%0d want 1/5", bus.f_gnt, bus.mem_addr);
        end
        next();
        reset = 1;
        drive(1, 6, 0, 0);
        @(negedge clk);
        nchk++;
        if ({bus.f_gnt, bus.d_gnt, bus.mem_en, bus.f_rvalid, bus.d_rvalid} !== 5'b0) begin
            nerr++; $display("FAIL rmid_during: got gnt f/d en rv f/d=%b%b%b%b%b want 00000", bus.f_gnt, bus.d_gnt, bus.mem_en, bus.f_rvalid, bus.d_rvalid);
        end
        next();
        reset = 0;
        @(negedge clk);
        nchk++;
        if ({bus.f_gnt, bus.f_rvalid, bus.mem_addr} !== {2'b10, AW'(6)}) begin
            nerr++; $display("FAIL rmid_after: got gnt=%b rv=%b addr=%0d want 1/0/6", bus.f_gnt, bus.f_rvalid, bus.mem_addr);
        end
        next();
        drive(0, 0, 0, 0);
        @(negedge clk);
        nchk++;
        if ({bus.f_rvalid, bus.f_rdata} !== {1'b1, word(6)}) begin
            nerr++; $display("FAIL rmid_ret: got rv=%b data=%h want 1/%h", bus.f_rvalid, bus.f_rdata, word(6));
        end
        next();
        @(negedge clk);
        nchk++;
        if (bus.f_rvalid !== 1'b0) begin
            nerr++; $display("FAIL rmid_extra: got rv=%b want 0", bus.f_rvalid);
        end
        next();
    endtask
    task automatic test_lat3();
        logic [AW-1:0] ga, ra;
        for (int c = 0; c < 7; c++) begin
            ga = c == 0 ? AW'(10) : c == 1 ? AW'(600) : c == 2 ? AW'(11) : '0;
            ra = c == 3 ? AW'(10) : c == 4 ? AW'(600) : AW'(11);
            bus3.f_req  = c == 0 || c == 2;
            bus3.d_req  = c == 1;
            bus3.f_addr = ga;
            bus3.d_addr = ga;
            @(negedge clk);
            nchk++;
            if ({bus3.f_gnt, bus3.d_gnt, bus3.mem_addr} !== {c == 0 || c == 2, c == 1, ga}) begin
                nerr++; $display("FAIL lat3_gnt%0d: got f/d=%b%b addr=%0d want %b%b/%0d", c, bus3.f_gnt, bus3.d_gnt, bus3.mem_addr, c == 0 || c == 2, c == 1, ga);
            end
            nchk++;
            if ({bus3.f_rvalid, bus3.d_rvalid} !== {c == 3 || c == 5, c == 4}) begin
                nerr++; $display("FAIL lat3_rv%0d: got f/d=%b%b want %b%b", c, bus3.f_rvalid, bus3.d_rvalid, c == 3 || c == 5, c == 4);
            end
            if (c >= 3 && c <= 5) begin
                nchk++;
                if ((c == 4 ? bus3.d_rdata : bus3.f_rdata) !== word(ra)) begin
                    nerr++; $display("FAIL lat3_data%0d: got %h want %h", c, c == 4 ? bus3.d_rdata : bus3.f_rdata, word(ra));
                end
            end
            next();
        end
    endtask
    task automatic test_random();
        logic fg = 1;
        logic dg = 1;
        for (int n = 0; n < 600; n++) begin
            reset = $urandom_range(0, 59) == 0;
            if (!bus.f_req || fg) begin
                bus.f_req  = $urandom_range(0, 7) != 0;
                bus.f_addr = AW'($urandom);
            end else if ($urandom_range(0, 15) == 0) bus.f_req = 0;
            if (!bus.d_req || dg) begin
                bus.d_req  = $urandom_range(0, 2) == 0;
                bus.d_addr = AW'($urandom);
            end else if ($urandom_range(0, 15) == 0) bus.d_req = 0;
            @(negedge clk);
            fg = e_fg;
            dg = e_dg;
            nchk++;
            if ({bus.f_gnt, bus.d_gnt, bus.mem_en, bus.d_prio} !== {e_fg, e_dg, e_fg | e_dg, e_dprio}) begin
                nerr++; $display("FAIL rnd_gnt@%0d: got f/d/en/prio=%b%b%b%b want %b%b%b%b", n, bus.f_gnt, bus.d_gnt, bus.mem_en, bus.d_prio, e_fg, e_dg, e_fg | e_dg, e_dprio);
            end
            nchk++;
            if (bus.mem_addr !== e_addr) begin
                nerr++; $display("FAIL rnd_addr@%0d: got %0d want %0d", n, bus.mem_addr, e_addr);
            end
            nchk++;
            if ({bus.f_rvalid, bus.d_rvalid} !== {e_fr, e_dr}) begin
                nerr++; $display("FAIL rnd_rv@%0d: got f/d=%b%b want %b%b", n, bus.f_rvalid, bus.d_rvalid, e_fr, e_dr);
            end
            if (e_fr || e_dr) begin
                nchk++;
                if ((e_dr ? bus.d_rdata : bus.f_rdata) !== word(q[0].addr)) begin
                    nerr++; $display("FAIL rnd_data@%0d: got %h want %h", n, e_dr ? bus.d_rdata : bus.f_rdata, word(q[0].addr));
                end
            end
            next();
        end
        reset = 0;
        drive(0, 0, 0, 0);
        next();
    endtask
    initial begin
        drive(0, 0, 0, 0);
        bus3.f_req  = 0;
        bus3.d_req  = 0;
        bus3.f_addr = '0;
        bus3.d_addr = '0;
        test_reset();
        test_fetch();
        test_starve();
        test_debug();
        test_withdraw();
        test_reset_mid();
        test_lat3();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-ported instruction memory between two requesters: port F (CPU instruction fetch) and port D (debug/loader read-back).
- Grants at most one read per cycle and drives the memory address.
- Tracks in-flight reads through a fixed-latency tag pipeline and routes each returned word to the port that issued it.
- Fetch has priority; an anti-starvation counter guarantees debug progress.

Parameters:
- ADDR_W, 10, word-address width; bit ADDR_W-1 selects the memory half.
- DATA_W, 32, instruction word width.
- RD_LATENCY, 1, cycles from mem_en/mem_addr to valid mem_dout; must be >= 1.
- STARVE_LIMIT, 4, consecutive cycles with D requesting and not granted before D gets priority; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- f_req  input  1  fetch read request; held until f_gnt.
- f_addr  input  ADDR_W  fetch word address.
- f_gnt  output  1  fetch request accepted this cycle (combinational).
- f_rvalid  output  1  f_rdata valid this cycle.
- f_rdata  output  DATA_W  fetch read data.
- d_req  input  1  debug read request; held until d_gnt.
- d_addr  input  ADDR_W  debug word address.
- d_gnt  output  1  debug request accepted this cycle (combinational).
- d_rvalid  output  1  d_rdata valid this cycle.
- d_rdata  output  DATA_W  debug read data.
- mem_en  output  1  read issued to memory this cycle.
- mem_addr  output  ADDR_W  address to memory.
- mem_dout  input  DATA_W  memory read data, RD_LATENCY cycles after issue.
- d_prio  output  1  debug-priority state active (status).

Behaviour:
- Reset values (reset high, sampled at the clock edge):
  - state = FPRI, starve_cnt = 0, tag pipeline all invalid.
  - While reset is high: f_gnt = d_gnt = mem_en = 0; f_rvalid = d_rvalid = 0; d_prio = 0.
  - mem_addr = 0 while idle and during reset.
- Grant (combinational, same cycle as request):
  - FPRI state: f_gnt = f_req; d_gnt = d_req & ~f_req.
  - DPRI state: d_gnt = d_req; f_gnt = f_req & ~d_req.
  - mem_en = f_gnt | d_gnt.
  - mem_addr = granted port's address; 0 when there is no grant.
- Never both grants in one cycle. A requester must keep req and addr stable until granted. Dropping req before the grant is legal; it withdraws the request.
- State machine:
  - FPRI: if d_req & ~d_gnt, starve_cnt increments. When starve_cnt reaches STARVE_LIMIT-1 while D is still denied, next state is DPRI and starve_cnt = 0. If d_gnt or ~d_req, starve_cnt = 0.
  - DPRI: if d_gnt or ~d_req, next state is FPRI and starve_cnt = 0. DPRI therefore lasts exactly one grant or one withdrawal.
  - d_prio = (state == DPRI).
- Tag pipeline:
  - RD_LATENCY stages of {valid, port}. Stage 0 loads {mem_en, d_gnt}; stages shift every cycle with no stall.
  - Tail valid with port=0 drives f_rvalid = 1; tail valid with port=1 drives d_rvalid = 1.
  - f_rdata = d_rdata = mem_dout, unqualified. Consumers qualify with rvalid.
- Throughput: one read per cycle, back-to-back. Responses return in issue order, exactly RD_LATENCY cycles after the grant.
- Memory half boundary: addresses 511 -> 512 need no special handling; the full ADDR_W address passes through unchanged.
- Reset mid-operation: in-flight tags are flushed. Reads granted before reset produce no rvalid after reset. Data arriving from the memory after reset is ignored.
- Simultaneous f_req and d_req with starve_cnt at STARVE_LIMIT-1 in FPRI: F wins this cycle and state moves to DPRI for the next cycle.
- Requests whose grant would have been in a cycle with reset high are not granted and must be re-held by the requester.

Test Plan:
1. Reset, then f_req=1 with f_addr=0,1,2 on consecutive cycles.
   -> f_gnt=1 each cycle; mem_addr=0,1,2.
   -> f_rvalid=1 at cycles +1,+2,+3 with f_rdata = mem words 0..2; d_rvalid stays 0.
2. f_req held continuously, d_req=1 with d_addr=512 from cycle 0, STARVE_LIMIT=4.
   -> d_gnt=0 for cycles 0..3; d_prio=1 in cycle 4; d_gnt=1 and f_gnt=0 in cycle 4 with mem_addr=512.
   -> d_rvalid=1 in cycle 5 with ROM2 word 0; f_gnt resumes in cycle 5.
3. d_req alone, addresses 513 and 514, back to back.
   -> d_gnt=1 immediately; d_rvalid two consecutive cycles with ROM2 words 1 and 2; starve_cnt stays 0.
4. Starve_cnt at 2, then d_req withdrawn.
   -> starve_cnt=0 next cycle; state remains FPRI; a later d_req must again wait 4 fetch-contended cycles.
5. Reset asserted one cycle after an f_gnt at addr 5.
   -> no f_rvalid after reset; all grants 0 during reset; the first post-reset f_req at addr 6 returns only the addr-6 data.
6. RD_LATENCY=3 build with alternating F/D grants at addrs 10, 600, 11.
   -> f_rvalid, d_rvalid, f_rvalid exactly 3 cycles after each respective grant, in order.
